sa_out_drain: RTL
=================

Name: sa_out_drain

Overview:
- Drain side of the SA_op systolic array.
- After the compute phase it issues channel_out_en pulses, captures the wide out bus for each pulse, and serializes it into fixed-width beats on a valid/ready stream toward the output buffer/writeback.
- At end of job it clears the array's channel logic with a one-cycle channel_out_reset.
- Handles both array modes: mode 0 (8x8, one channel per pulse) and mode 1 (1x8, two filter channels f0/f1 per pulse).

Parameters:
- COLUMN_NUM, 32, array columns.
- PIXEL_WIDTH_88, 24, mode-0 accumulator width.
- PIXEL_WIDTH_18, 16, mode-1 accumulator width.
- OUT_WIDTH, 2048, out bus width (PIXEL_WIDTH_18*2*2*COLUMN_NUM).
- BEAT_WIDTH, 256, downstream data width; must divide 1536 and 1024.
- OUT_LATENCY, 1, cycles from channel_out_en high to out valid (1..3).
- CH_CNT_WIDTH, 10, channel-count width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle job start; sampled only in IDLE.
- mode, input, 1, 0 = 8x8, 1 = 1x8; latched at start.
- num_channels, input, CH_CNT_WIDTH, output channels in job (>=1); latched at start.
- channel_out_en, output, 1, to SA_op; one-cycle pulse per capture.
- channel_out_reset, output, 1, to SA_op; one-cycle pulse at job end.
- out, input, OUT_WIDTH, SA_op result bus.
- m_valid, output, 1, beat valid.
- m_ready, input, 1, downstream accept.
- m_data, output, BEAT_WIDTH, beat payload.
- m_last, output, 1, final beat of job.
- busy, output, 1, high outside IDLE.
- done, output, 1, one-cycle pulse with channel_out_reset.

Behaviour:
- Reset (synchronous, active-high; wins over every other event including mid-job): state IDLE; all outputs 0; counters and capture buffer 0. A reset mid-job abandons the job; SA_op is not cleared by this block.
- FSM states: IDLE, PULSE, WAIT, CAPTURE, SEND, CLEAR.
- IDLE: on start, latch mode and num_channels; go to PULSE. A start of num_channels=0 is ignored.
- PULSE: channel_out_en=1 for exactly one cycle. Go to WAIT, or straight to CAPTURE when OUT_LATENCY=1.
- WAIT: count OUT_LATENCY-1 cycles, then go to CAPTURE.
- CAPTURE: load capture buffer from out on this edge. The out bus is sampled exactly OUT_LATENCY cycles after the channel_out_en cycle. Set beat count:
  - mode 0: 1536/BEAT_WIDTH = 6, slice out[1535:0].
  - mode 1: 8 beats, f0 = out[1023:0] then f1 = out[2047:1024].
  - mode 1 with one channel remaining: 4 beats (f0 only).
- SEND: m_data = current BEAT_WIDTH slice, lowest slice first. Beat k of a pulse = buffer[k*BEAT_WIDTH +: BEAT_WIDTH].
  - m_valid is held high; m_data is stable while m_valid && !m_ready.
  - Advance only on m_valid && m_ready; no beat is dropped or duplicated under arbitrary backpressure.
  - Back-to-back beats are allowed (1 beat/cycle when m_ready is held).
- After the last beat of a pulse: remaining = remaining - channels_in_pulse (1 in mode 0; 2, or 1 if odd tail, in mode 1). If remaining > 0, go to PULSE; else go to CLEAR.
- Pulse spacing: consecutive channel_out_en pulses are separated by at least one low cycle; this follows from SEND being at least 4 cycles.
- m_last = 1 only on the final beat of the job.
- CLEAR: channel_out_reset=1 and done=1 for one cycle, then IDLE.
- start while busy: ignored.
- Beat counts: total beats = 6*N (mode 0), or 8*floor(N/2) + 4*(N mod 2) (mode 1).
- Mode and out are not re-sampled outside the latch and CAPTURE edges.

Decomposition:
- Shared package sa_pkg:
  - widths: PIXEL_WIDTH_88/18, COLUMN_NUM, OUT_WIDTH, OUT_WIDTH_88 = 1536, OUT_WIDTH_18 = 2048;
  - mode encodings MODE_88 = 0, MODE_18 = 1;
  - FSM state enum.
- One natural sub-module: sa_beat_serializer. It holds the capture buffer and beat index, runs the valid/ready handshake and reports a last-beat flag; the top holds the FSM and channel counters.

Test Plan:
- Mode 0, N=2, m_ready=1, bench SA model drives out = {pulse#, slice#} pattern at the latency point: exactly 2 channel_out_en pulses with at least one idle cycle between them; 12 beats in order slice0..5 of channel 0 then channel 1; m_last on beat 12; one channel_out_reset/done cycle then IDLE.
- Mode 1, N=3: 2 pulses; first yields 8 beats (f0 slices 0..3, then f1 from out[1024+]), second yields 4 f0 beats; total 12 beats, m_last on beat 12.
- Backpressure: m_ready random 30%, mode 0, N=4: 24 beats match the model exactly; m_data is stable during every stall cycle; no channel_out_en while beats are pending.
- OUT_LATENCY=3: the SA model drives garbage except at exactly 3 cycles after the pulse; the captured data equals the valid value.
- Reset asserted mid-SEND (beat 3 of 6): next cycle all outputs are 0 and state is IDLE; a fresh start with N=1 gives 6 clean beats.
- start pulsed while busy, and start with num_channels=0: both ignored; no channel_out_en issued.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared widths, mode encodings and drain FSM states for the SA_op drain path
package sa_pkg;

    localparam int COLUMN_NUM     = 32;
    localparam int PIXEL_WIDTH_88 = 24;
    localparam int PIXEL_WIDTH_18 = 16;
    localparam int OUT_WIDTH      = PIXEL_WIDTH_18 * 2 * 2 * COLUMN_NUM;
    localparam int OUT_WIDTH_88   = 1536;
    localparam int OUT_WIDTH_18   = 2048;

    localparam logic MODE_88 = 1'b0;
    localparam logic MODE_18 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT,
        ST_CAPTURE,
        ST_SEND,
        ST_CLEAR
    } drain_state_e;

endpackage

// File: rtl/sa_beat_serializer.sv
// rtl/sa_beat_serializer.sv - capture buffer that emits one wide result as fixed-width valid/ready beats
module sa_beat_serializer #(
    parameter int BUF_WIDTH  = 2048,
    parameter int BEAT_WIDTH = 256,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [BUF_WIDTH-1:0]  load_data,
    input  logic [CNT_WIDTH-1:0]  load_beats,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BEAT_WIDTH-1:0] m_data,
    output logic                  last_beat,
    output logic                  beat_done
);

    // The buffer shifts down one slice per accepted beat, so the current
    // beat is always the low slice and stays put while the sink stalls.
    logic [BUF_WIDTH-1:0] buffer;
    logic [CNT_WIDTH-1:0] beats_left;
    logic                 valid;

    // Load on capture, then step one slice per handshake until empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer     <= '0;
            beats_left <= '0;
            valid      <= 1'b0;
        end else if (load) begin
            buffer     <= load_data;
            beats_left <= load_beats;
            valid      <= (load_beats != '0);
        end else if (valid && m_ready) begin
            buffer     <= buffer >> BEAT_WIDTH;
            beats_left <= beats_left - CNT_WIDTH'(1);
            if (beats_left == CNT_WIDTH'(1)) begin
                valid <= 1'b0;
            end
        end
    end

    // Present the low slice and flag the final beat of this capture.
    always_comb begin
        m_valid   = valid;
        m_data    = buffer[BEAT_WIDTH-1:0];
        last_beat = valid && (beats_left == CNT_WIDTH'(1));
        beat_done = valid && m_ready && (beats_left == CNT_WIDTH'(1));
    end

endmodule

// File: rtl/sa_out_drain.sv
// rtl/sa_out_drain.sv - pulses SA_op channel outputs, captures the out bus and streams it as beats
module sa_out_drain #(
    parameter int COLUMN_NUM     = 32,
    parameter int PIXEL_WIDTH_88 = 24,
    parameter int PIXEL_WIDTH_18 = 16,
    parameter int OUT_WIDTH      = PIXEL_WIDTH_18 * 2 * 2 * COLUMN_NUM,
    parameter int BEAT_WIDTH     = 256,
    parameter int OUT_LATENCY    = 1,
    parameter int CH_CNT_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [CH_CNT_WIDTH-1:0] num_channels,
    output logic                    channel_out_en,
    output logic                    channel_out_reset,
    input  logic [OUT_WIDTH-1:0]    out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BEAT_WIDTH-1:0]   m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done
);

    import sa_pkg::*;

    // Mode 0 only drives the low 8x8 accumulators; mode 1 uses the whole bus
    // with filter f0 in the low half and f1 in the high half.
    localparam int CAP_WIDTH_88    = PIXEL_WIDTH_88 * 2 * COLUMN_NUM;
    localparam int HALF_WIDTH      = OUT_WIDTH / 2;
    localparam int BEATS_88        = CAP_WIDTH_88 / BEAT_WIDTH;
    localparam int BEATS_18_PAIR   = OUT_WIDTH / BEAT_WIDTH;
    localparam int BEATS_18_TAIL   = HALF_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_WIDTH  = $clog2(BEATS_18_PAIR + 1);

    drain_state_e              state;
    drain_state_e              next_state;
    logic                      mode_q;
    logic [CH_CNT_WIDTH-1:0]   remaining;
    logic [CH_CNT_WIDTH-1:0]   chans_in_pulse;
    logic                      final_pulse;
    logic [1:0]                wait_cnt;
    logic                      load;
    logic [OUT_WIDTH-1:0]      capture_data;
    logic [BEAT_CNT_WIDTH-1:0] capture_beats;
    logic                      last_beat;
    logic                      beat_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Job bookkeeping: latched mode, channels still to drain, latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_88;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (num_channels != '0)) begin
                        mode_q    <= mode;
                        remaining <= num_channels;
                    end
                end
                ST_PULSE: wait_cnt <= '0;
                ST_WAIT:  wait_cnt <= wait_cnt + 2'd1;
                ST_SEND: begin
                    if (beat_done) begin
                        remaining <= remaining - chans_in_pulse;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channels covered by the current pulse: a mode-1 pulse carries two
    // filters unless only the odd tail channel is left.
    always_comb begin
        chans_in_pulse = CH_CNT_WIDTH'(1);
        if ((mode_q == MODE_18) && (remaining != CH_CNT_WIDTH'(1))) begin
            chans_in_pulse = CH_CNT_WIDTH'(2);
        end
        final_pulse = (remaining <= chans_in_pulse);
    end

    // Capture slice and beat count for the current pulse.
    always_comb begin
        capture_data  = '0;
        capture_beats = BEAT_CNT_WIDTH'(BEATS_88);
        if (mode_q == MODE_18) begin
            capture_data = out;
            if (remaining == CH_CNT_WIDTH'(1)) begin
                capture_beats = BEAT_CNT_WIDTH'(BEATS_18_TAIL);
            end else begin
                capture_beats = BEAT_CNT_WIDTH'(BEATS_18_PAIR);
            end
        end else begin
            capture_data[CAP_WIDTH_88-1:0] = out[CAP_WIDTH_88-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start && (num_channels != '0)) begin
                    next_state = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (OUT_LATENCY > 1) begin
                    next_state = ST_WAIT;
                end else begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (int'(wait_cnt) >= OUT_LATENCY - 2) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: next_state = ST_SEND;
            ST_SEND: begin
                if (beat_done) begin
                    next_state = final_pulse ? ST_CLEAR : ST_PULSE;
                end
            end
            ST_CLEAR: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        channel_out_en    = (state == ST_PULSE);
        channel_out_reset = (state == ST_CLEAR);
        done              = (state == ST_CLEAR);
        busy              = (state != ST_IDLE);
        load              = (state == ST_CAPTURE);
        m_last            = m_valid && last_beat && final_pulse;
    end

    sa_beat_serializer #(
        .BUF_WIDTH  (OUT_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .CNT_WIDTH  (BEAT_CNT_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (capture_data),
        .load_beats (capture_beats),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .last_beat  (last_beat),
        .beat_done  (beat_done)
    );

endmodule
